// File: rtl/pbit_tanh_pipe.sv
`default_nettype none
// ============================================================================
// Module      : pbit_tanh_pipe
// Description : Multi-channel pipelined p-bit activation. Each channel scales
//               its input by 2^beta, evaluates a 3-segment piecewise-linear
//               tanh and compares it with an LFSR sample to form a p-bit.
// Revision    : 1.0  initial release
// ============================================================================
module pbit_tanh_pipe #(
    parameter int          N_CH      = 4,
    parameter int          IN_BITS   = 6,
    parameter int          FRAC_BITS = 2,
    parameter int          OUT_BITS  = 16,
    parameter int          BETA_BITS = 3,
    parameter logic [31:0] SEED      = 32'h0000_0001
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [N_CH*IN_BITS-1:0]    in_data,
    input  logic [BETA_BITS-1:0]       beta_shift,
    input  logic                       rand_en,
    output logic                       out_valid,
    output logic [N_CH*OUT_BITS-1:0]   out_tanh,
    output logic [N_CH-1:0]            out_m
);

    // |in| needs IN_BITS+1 bits; the largest shift adds 2^BETA_BITS-1 more.
    localparam int c_sh_w = IN_BITS + (1 << BETA_BITS);
    localparam int c_lo   = OUT_BITS - 1 - FRAC_BITS;

    localparam logic [OUT_BITS-1:0] c_q_half    = {2'b01, {(OUT_BITS-2){1'b0}}};
    localparam logic [OUT_BITS-1:0] c_q_quarter = {3'b001, {(OUT_BITS-3){1'b0}}};
    localparam logic [OUT_BITS-1:0] c_q_max     = {1'b0, {(OUT_BITS-1){1'b1}}};

    logic r_v1;
    logic r_v2;
    logic r_v3;
    logic r_re1;
    logic r_re2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1  <= 1'b0;
            r_v2  <= 1'b0;
            r_v3  <= 1'b0;
            r_re1 <= 1'b0;
            r_re2 <= 1'b0;
        end else begin
            r_v1 <= in_valid;
            r_v2 <= r_v1;
            r_v3 <= r_v2;
            if (in_valid) begin
                r_re1 <= rand_en;
            end
            if (r_v1) begin
                r_re2 <= r_re1;
            end
        end
    end

    assign out_valid = r_v3;

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            localparam logic [31:0] c_seed = SEED + 32'(gi);

            logic [IN_BITS-1:0]  w_in;
            logic [IN_BITS:0]    w_abs;
            logic [c_sh_w-1:0]   w_sh;
            logic                w_sat;
            logic [OUT_BITS-1:0] w_a;

            assign w_in  = in_data[gi*IN_BITS +: IN_BITS];
            assign w_abs = w_in[IN_BITS-1] ? (~{w_in[IN_BITS-1], w_in} + 1'b1)
                                           : {1'b0, w_in};
            assign w_sh  = {{(c_sh_w-IN_BITS-1){1'b0}}, w_abs} << beta_shift;
            // Any bit at or above the 2.0 position means the input saturates.
            assign w_sat = |w_sh[c_sh_w-1:FRAC_BITS+1];
            assign w_a   = {w_sh[FRAC_BITS:0], {c_lo{1'b0}}};

            logic                r_s1;
            logic                r_sat1;
            logic [OUT_BITS-1:0] r_a1;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_s1   <= 1'b0;
                    r_sat1 <= 1'b0;
                    r_a1   <= '0;
                end else if (in_valid) begin
                    r_s1   <= w_in[IN_BITS-1];
                    r_sat1 <= w_sat;
                    r_a1   <= w_a;
                end
            end

            logic [OUT_BITS-1:0] w_mag;
            logic [OUT_BITS-1:0] w_y;

            always_comb begin
                w_mag = c_q_max;
                if (!r_sat1) begin
                    if (r_a1[OUT_BITS-1]) begin
                        w_mag = (r_a1 >> 2) + c_q_half;
                    end else if (r_a1[OUT_BITS-2]) begin
                        w_mag = (r_a1 >> 1) + c_q_quarter;
                    end else begin
                        w_mag = r_a1;
                    end
                end
            end

            // Magnitude never exceeds Q-1, so negation cannot reach -Q.
            assign w_y = r_s1 ? (~w_mag + 1'b1) : w_mag;

            logic [OUT_BITS-1:0] r_y2;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_y2 <= '0;
                end else if (r_v1) begin
                    r_y2 <= w_y;
                end
            end

            logic [31:0]         r_lfsr;
            logic [31:0]         w_lfsr_nx;
            logic [OUT_BITS-1:0] w_r;
            logic                w_gt;
            logic                w_m;
            logic [OUT_BITS-1:0] r_tanh;
            logic                r_m;

            assign w_lfsr_nx = {r_lfsr[30:0], r_lfsr[31] ^ r_lfsr[21] ^ r_lfsr[1] ^ r_lfsr[0]};
            assign w_r       = r_lfsr[31 -: OUT_BITS];
            assign w_gt      = $signed(r_y2) > $signed(w_r);
            assign w_m       = r_re2 ? w_gt : ~r_y2[OUT_BITS-1];

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_lfsr <= c_seed;
                    r_tanh <= '0;
                    r_m    <= 1'b0;
                end else if (r_v2) begin
                    r_lfsr <= w_lfsr_nx;
                    r_tanh <= r_y2;
                    r_m    <= w_m;
                end
            end

            assign out_tanh[gi*OUT_BITS +: OUT_BITS] = r_tanh;
            assign out_m[gi]                         = r_m;
        end
    endgenerate

endmodule
`default_nettype wire
